// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type and counter-width helper for the serializer
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } piso_state_t;

  // Bits needed to count 0..max_count-1; never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel-side valid/ready handshake bundle
interface piso_serializer_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - clear-on-load up counter that parks at its terminal value
module piso_bit_counter #(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic terminal_count
);

  localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count;

  // Count up while enabled; load restarts from zero and wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !terminal_count) begin
      count <= count + 1'b1;
    end
  end

  assign terminal_count = (count == TC_VALUE);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out serializer with optional inter-word gap
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  piso_serializer_if.slave  up,
  output logic              serial_out,
  output logic              frame,
  output logic              done
);

  localparam int BIT_CNT_W = cnt_width(DATA_WIDTH);

  piso_state_t           state;
  piso_state_t           state_next;
  logic                  handshake;
  logic                  bit_load;
  logic                  bit_tc;
  logic                  bit_last;
  logic                  gap_last;
  logic [DATA_WIDTH-1:0] shadow;

  // Bit counter tracks which bit is on serial_out; it restarts outside SHIFT and
  // after every last bit so a back-to-back word begins at index 0.
  piso_bit_counter #(
    .WIDTH    (BIT_CNT_W),
    .TERMINAL (DATA_WIDTH - 1)
  ) u_bit_counter (
    .clk            (clk),
    .reset          (reset),
    .load           (bit_load),
    .enable         (state == SHIFT),
    .terminal_count (bit_tc)
  );

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam int GAP_CNT_W = cnt_width(GAP_CYCLES + 1);
      logic gap_tc;

      piso_bit_counter #(
        .WIDTH    (GAP_CNT_W),
        .TERMINAL (GAP_CYCLES - 1)
      ) u_gap_counter (
        .clk            (clk),
        .reset          (reset),
        .load           (state != GAP),
        .enable         (state == GAP),
        .terminal_count (gap_tc)
      );

      assign gap_last = (state == GAP) && gap_tc;
    end else begin : g_no_gap
      assign gap_last = 1'b0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) state_next = SHIFT;
      end
      SHIFT: begin
        if (bit_last) begin
          if (GAP_CYCLES > 0)  state_next = GAP;
          else if (handshake)  state_next = SHIFT;
          else                 state_next = IDLE;
        end
      end
      GAP: begin
        if (gap_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs and counter control decoded from state; ready is held low during reset.
  always_comb begin
    bit_last      = (state == SHIFT) && bit_tc;
    frame         = (state == SHIFT);
    done          = bit_last;
    up.data_ready = !reset && ((state == IDLE) || (bit_last && (GAP_CYCLES == 0)));
    handshake     = up.data_valid && up.data_ready;
    bit_load      = (state != SHIFT) || bit_last;
  end

  // Shadow shift register and registered serial bit; the first bit is taken straight
  // from data_in on the handshake edge so it appears one cycle after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow     <= '0;
      serial_out <= 1'b0;
    end else if (handshake) begin
      serial_out <= MSB_FIRST ? up.data_in[DATA_WIDTH-1] : up.data_in[0];
      shadow     <= MSB_FIRST ? (up.data_in << 1) : (up.data_in >> 1);
    end else if ((state == SHIFT) && !bit_tc) begin
      serial_out <= MSB_FIRST ? shadow[DATA_WIDTH-1] : shadow[0];
      shadow     <= MSB_FIRST ? (shadow << 1) : (shadow >> 1);
    end else begin
      serial_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

  logic clk;
  logic reset;
  logic s0, f0, d0;
  logic sg, fg, dg;
  logic sl, fl, dl;
  int   n_run;
  int   n_fail;
  logic [7:0] w1;
  logic [7:0] w2;

  piso_serializer_if #(.DATA_WIDTH(8)) if0 ();
  piso_serializer_if #(.DATA_WIDTH(8)) ifg ();
  piso_serializer_if #(.DATA_WIDTH(8)) ifl ();

  piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .up(if0), .serial_out(s0), .frame(f0), .done(d0)
  );

  piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_gap (
    .clk(clk), .reset(reset), .up(ifg), .serial_out(sg), .frame(fg), .done(dg)
  );

  piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_lsb (
    .clk(clk), .reset(reset), .up(ifl), .serial_out(sl), .frame(fl), .done(dl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    if0.data_in = 8'h00; if0.data_valid = 1'b0;
    ifg.data_in = 8'h00; ifg.data_valid = 1'b0;
    ifl.data_in = 8'h00; ifl.data_valid = 1'b0;

    // 1: reset held three cycles with valid offered
    reset = 1'b1;
    if0.data_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("rst%0d serial", i), 32'(s0), 32'd0);
      chk($sformatf("rst%0d frame", i), 32'(f0), 32'd0);
      chk($sformatf("rst%0d done", i), 32'(d0), 32'd0);
      chk($sformatf("rst%0d ready", i), 32'(if0.data_ready), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("rst release ready", 32'(if0.data_ready), 32'd1);
    if0.data_valid = 1'b0;
    tick();

    // 2: single word A5, MSB first
    w1 = 8'hA5;
    if0.data_in = w1;
    if0.data_valid = 1'b1;
    tick();
    if0.data_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t2 +%0d serial", i), 32'(s0), 32'(w1[8-i]));
      chk($sformatf("t2 +%0d frame", i), 32'(f0), 32'd1);
      chk($sformatf("t2 +%0d done", i), 32'(d0), (i == 8) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t2 +9 frame", 32'(f0), 32'd0);
    chk("t2 +9 ready", 32'(if0.data_ready), 32'd1);

    // 3: back-to-back FF then 00, no gap
    if0.data_in = 8'hFF;
    if0.data_valid = 1'b1;
    tick();
    if0.data_in = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      if (i == 9) if0.data_valid = 1'b0;
      chk($sformatf("t3 +%0d serial", i), 32'(s0), (i <= 8) ? 32'd1 : 32'd0);
      chk($sformatf("t3 +%0d frame", i), 32'(f0), 32'd1);
      chk($sformatf("t3 +%0d done", i), 32'(d0), (i == 8 || i == 16) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t3 +17 frame", 32'(f0), 32'd0);

    // 4: GAP_CYCLES = 2, words A5 then 3C queued
    w1 = 8'hA5;
    w2 = 8'h3C;
    ifg.data_in = w1;
    ifg.data_valid = 1'b1;
    tick();
    ifg.data_in = w2;
    for (int i = 1; i <= 20; i++) begin
      logic exp_s;
      if (i == 12) ifg.data_valid = 1'b0;
      if (i <= 8) exp_s = w1[8-i];
      else if (i >= 12 && i <= 19) exp_s = w2[19-i];
      else exp_s = 1'b0;
      chk($sformatf("t4 +%0d serial", i), 32'(sg), 32'(exp_s));
      chk($sformatf("t4 +%0d frame", i), 32'(fg),
          ((i <= 8) || (i >= 12 && i <= 19)) ? 32'd1 : 32'd0);
      chk($sformatf("t4 +%0d ready", i), 32'(ifg.data_ready), (i == 11) ? 32'd1 : 32'd0);
      chk($sformatf("t4 +%0d done", i), 32'(dg), (i == 8 || i == 19) ? 32'd1 : 32'd0);
      tick();
    end

    // 5: reset after bit 4 of C3
    w1 = 8'hC3;
    if0.data_in = w1;
    if0.data_valid = 1'b1;
    tick();
    if0.data_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t5 +%0d serial", i), 32'(s0), 32'(w1[8-i]));
      chk($sformatf("t5 +%0d frame", i), 32'(f0), 32'd1);
      if (i < 4) tick();
    end
    reset = 1'b1;
    tick();
    chk("t5 rst frame", 32'(f0), 32'd0);
    chk("t5 rst done", 32'(d0), 32'd0);
    chk("t5 rst serial", 32'(s0), 32'd0);
    chk("t5 rst ready", 32'(if0.data_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("t5 release ready", 32'(if0.data_ready), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("t5 idle%0d frame", i), 32'(f0), 32'd0);
      chk($sformatf("t5 idle%0d done", i), 32'(d0), 32'd0);
    end

    // 6: LSB first, data_in 01 then changed to FF after the handshake
    ifl.data_in = 8'h01;
    ifl.data_valid = 1'b1;
    tick();
    ifl.data_in = 8'hFF;
    ifl.data_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t6 +%0d serial", i), 32'(sl), (i == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t6 +%0d frame", i), 32'(fl), 32'd1);
      chk($sformatf("t6 +%0d done", i), 32'(dl), (i == 8) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t6 +9 frame", 32'(fl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
